// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared types and constants for the line-clear sequencer
//
// Purpose : sequencer state encoding, playfield geometry and small helpers.
// Contents: state_e, MAP_ROWS, MAP_COLS, ROW_IDX_W, FLASH_CNT_W, sat_inc3()
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_FLASH = 3'd2,
    ST_CLEAR = 3'd3,
    ST_SPAWN = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  localparam int MAP_ROWS    = 8;
  localparam int MAP_COLS    = 8;
  localparam int ROW_IDX_W   = 3;
  localparam int FLASH_CNT_W = 24;

  // Line counter stops at 7 so a huge cascade never wraps back to a small value.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// rtl/row_full_detect.sv - combinational full-row finder for the 8x8 playfield
//
// Purpose : flags whether any row is completely filled and returns the
//           lowest-on-screen (highest-index) full row.
// Ports   : occ_map  in  [0:7][0:7] occupancy, row 0 top, 1 = filled
//           any_full out at least one row has all bits set
//           full_idx out highest-index full row (0 when any_full is low)
module row_full_detect
  import tetris_pkg::*;
(
  input  logic [0:MAP_ROWS-1][0:MAP_COLS-1] occ_map,
  output logic                              any_full,
  output logic [ROW_IDX_W-1:0]              full_idx
);

  // Ascending scan: a later (lower on screen) full row overrides an earlier one.
  always_comb begin
    any_full = 1'b0;
    full_idx = '0;
    for (int r = 0; r < MAP_ROWS; r++) begin
      if (&occ_map[r]) begin
        any_full = 1'b1;
        full_idx = ROW_IDX_W'(r);
      end
    end
  end

endmodule

// File: rtl/line_clear_sequencer.sv
// rtl/line_clear_sequencer.sv - post-lock row flash/remove/spawn sequencer
//
// Purpose : after a block locks, repeatedly finds the lowest full row, flashes
//           it for FLASH_CYCLES clocks, hands it to the map owner for removal,
//           and finally either requests the next block or declares game over.
// Ports   : clk, reset (sync, active high)
//           lock_req      in  block merged into map (pulse)
//           occ_map       in  [0:7][0:7] occupancy, row 0 top
//           row_clear_ack in  map owner removed row_clear_idx
//           busy          out not idle
//           flash_en      out flash phase active
//           row_clear_req out removal request, held until ack
//           row_clear_idx out row being flashed/removed
//           score_plus    out one pulse per removed row
//           lines_cleared out rows removed since last accepted lock_req
//           spawn_req     out one pulse: load next block
//           game_over     out sticky end-of-game flag
module line_clear_sequencer
  import tetris_pkg::*;
#(
  parameter int unsigned FLASH_CYCLES = 12_000_000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              lock_req,
  input  logic [0:MAP_ROWS-1][0:MAP_COLS-1] occ_map,
  input  logic                              row_clear_ack,
  output logic                              busy,
  output logic                              flash_en,
  output logic                              row_clear_req,
  output logic [ROW_IDX_W-1:0]              row_clear_idx,
  output logic                              score_plus,
  output logic [2:0]                        lines_cleared,
  output logic                              spawn_req,
  output logic                              game_over
);

  state_e                 state_q, state_d;
  logic [FLASH_CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]             lines_q, lines_d;
  logic                   busy_q, flash_en_q, req_q, score_q, spawn_q, over_q;

  logic                   any_full;
  logic [ROW_IDX_W-1:0]   full_idx;

  row_full_detect u_row_full_detect (
    .occ_map  (occ_map),
    .any_full (any_full),
    .full_idx (full_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lines_d = lines_q;
    case (state_q)
      ST_IDLE: begin
        if (lock_req) begin
          state_d = ST_SCAN;
          lines_d = 3'd0;
        end
      end
      ST_SCAN: begin
        if (any_full) begin
          idx_d   = full_idx;
          cnt_d   = FLASH_CNT_W'(FLASH_CYCLES - 1);
          state_d = ST_FLASH;
        end else if (|occ_map[0]) begin
          // Nothing to clear and the top row is occupied: no room to spawn.
          state_d = ST_OVER;
        end else begin
          state_d = ST_SPAWN;
        end
      end
      ST_FLASH: begin
        if (cnt_q == '0) state_d = ST_CLEAR;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_CLEAR: begin
        // Return to SCAN so rows shifted down by the removal get re-checked.
        if (row_clear_ack) begin
          lines_d = sat_inc3(lines_q);
          state_d = ST_SCAN;
        end
      end
      ST_SPAWN: state_d = ST_IDLE;
      ST_OVER:  state_d = ST_OVER;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // they describe while still coming straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      lines_q    <= 3'd0;
      busy_q     <= 1'b0;
      flash_en_q <= 1'b0;
      req_q      <= 1'b0;
      score_q    <= 1'b0;
      spawn_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lines_q    <= lines_d;
      busy_q     <= (state_d != ST_IDLE);
      flash_en_q <= (state_d == ST_FLASH);
      req_q      <= (state_d == ST_CLEAR);
      score_q    <= (state_q == ST_CLEAR) && row_clear_ack;
      spawn_q    <= (state_d == ST_SPAWN);
      over_q     <= (state_d == ST_OVER);
    end
  end

  assign busy          = busy_q;
  assign flash_en      = flash_en_q;
  assign row_clear_req = req_q;
  assign row_clear_idx = idx_q;
  assign score_plus    = score_q;
  assign lines_cleared = lines_q;
  assign spawn_req     = spawn_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_line_clear_sequencer.sv
// tb/tb_line_clear_sequencer.sv - directed self-checking bench for line_clear_sequencer
module tb_line_clear_sequencer;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             lock_req = 1'b0;
  logic [0:7][0:7]  occ = '0;
  logic             ack = 1'b0;
  logic             busy, flash_en, row_clear_req, score_plus, spawn_req, game_over;
  logic [2:0]       row_clear_idx, lines_cleared;

  int checks = 0;
  int failures = 0;

  line_clear_sequencer #(.FLASH_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .lock_req      (lock_req),
    .occ_map       (occ),
    .row_clear_ack (ack),
    .busy          (busy),
    .flash_en      (flash_en),
    .row_clear_req (row_clear_req),
    .row_clear_idx (row_clear_idx),
    .score_plus    (score_plus),
    .lines_cleared (lines_cleared),
    .spawn_req     (spawn_req),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards apply to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lock_req = 1'b0;
    ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {busy, flash_en, row_clear_req, score_plus, spawn_req, game_over}, 6'b0);
    chk({tag, "_idx"}, row_clear_idx, 3'd0);
    chk({tag, "_lines"}, lines_cleared, 3'd0);
  endtask

  // Map owner: drop row r, shift rows above down, empty row 0.
  task automatic remove_row(input int r);
    for (int k = r; k > 0; k--) occ[k] = occ[k-1];
    occ[0] = 8'h00;
  endtask

  task automatic pulse_lock();
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
  endtask

  // Entered on the first FLASH cycle; leaves on the SCAN cycle after the ack.
  task automatic do_row(input string tag, input logic [2:0] exp_idx, input int ack_wait,
                        input logic [2:0] exp_lines);
    int n = 0;
    while (flash_en && n < 50) begin
      chk({tag, "_flash_idx"}, row_clear_idx, exp_idx);
      n++;
      tick();
    end
    chk({tag, "_flash_len"}, n, 4);
    chk({tag, "_req"}, row_clear_req, 1'b1);
    chk({tag, "_idx"}, row_clear_idx, exp_idx);
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      chk({tag, "_hold"}, {row_clear_req, score_plus, row_clear_idx}, {2'b10, exp_idx});
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    remove_row(int'(exp_idx));
    chk({tag, "_score"}, score_plus, 1'b1);
    chk({tag, "_req_drop"}, row_clear_req, 1'b0);
    chk({tag, "_lines"}, lines_cleared, exp_lines);
    tick();
    chk({tag, "_score_once"}, score_plus, 1'b0);
  endtask

  initial begin
    int spawns;

    // Reset state and plain spawn latency.
    do_reset();
    check_all_zero("rst");
    tick();
    pulse_lock();
    chk("t1_n1_busy", busy, 1'b1);
    chk("t1_n1_spawn", spawn_req, 1'b0);
    tick();
    chk("t1_n2_spawn", spawn_req, 1'b1);
    chk("t1_n2_busy", busy, 1'b1);
    chk("t1_lines", lines_cleared, 3'd0);
    tick();
    chk("t1_n3_spawn", spawn_req, 1'b0);
    chk("t1_n3_busy", busy, 1'b0);

    // Rows 6 and 7 full: row 7 removed twice (row 6 drops into it).
    occ = '0;
    occ[6] = 8'hFF;
    occ[7] = 8'hFF;
    occ[5] = 8'h81;
    pulse_lock();
    tick();
    do_row("t2a", 3'd7, 1, 3'd1);
    // After first removal the old row 6 sits in row 7 and is full again.
    do_row("t2b", 3'd7, 1, 3'd2);
    chk("t2_spawn", spawn_req, 1'b1);
    chk("t2_lines", lines_cleared, 3'd2);
    tick();
    chk("t2_idle", {busy, spawn_req}, 2'b00);

    // Top row occupied, nothing full: game over, further locks ignored.
    do_reset();
    occ = '0;
    occ[0] = 8'h08;
    pulse_lock();
    tick();
    chk("t3_over", game_over, 1'b1);
    chk("t3_spawn", spawn_req, 1'b0);
    spawns = 0;
    lock_req = 1'b1;
    ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      spawns += int'(spawn_req);
    end
    lock_req = 1'b0;
    ack = 1'b0;
    chk("t3_no_spawn", spawns, 0);
    chk("t3_sticky", {game_over, busy, row_clear_req}, 3'b110);

    // Ack withheld 20 cycles.
    do_reset();
    occ = '0;
    occ[7] = 8'hFF;
    occ[6] = 8'h3C;
    pulse_lock();
    tick();
    do_row("t4", 3'd7, 20, 3'd1);
    chk("t4_spawn", spawn_req, 1'b1);

    // Reset in the middle of FLASH.
    do_reset();
    occ = '0;
    occ[4] = 8'hFF;
    pulse_lock();
    tick();
    chk("t5_flash1", flash_en, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("t5_rst");
    occ = '0;
    pulse_lock();
    chk("t5_n1_spawn", spawn_req, 1'b0);
    tick();
    chk("t5_n2_spawn", spawn_req, 1'b1);

    // lock_req during FLASH must not add a second spawn.
    do_reset();
    occ = '0;
    occ[7] = 8'hFF;
    pulse_lock();
    tick();
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    spawns = 0;
    for (int i = 0; i < 40; i++) begin
      ack = 1'b0;
      if (row_clear_req) begin
        ack = 1'b1;
        occ[7] = 8'h00;
      end
      tick();
      spawns += int'(spawn_req);
    end
    ack = 1'b0;
    chk("t6_spawns", spawns, 1);
    chk("t6_lines", lines_cleared, 3'd1);
    chk("t6_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
